// File: rtl/seq_comparator.sv
// Bit-serial three-way magnitude/equality comparator, MSB-first with early exit at the first differing bit.
// Latency 2..WIDTH+1 cycles from start to done; start is ignored while busy, and all outputs are registered.
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;

    assign cnt_n = cnt + CW'(1);

    // Operands shift left so the bit under test is always the MSB; cnt==0 marks the sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sm_q   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sm_q  <= signed_mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    cnt <= cnt_n;
                    if (a_q[WIDTH-1] != b_q[WIDTH-1]) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        eq     <= 1'b0;
                        cycles <= cnt_n;
                        // A set sign bit means the more negative operand.
                        if (sm_q && (cnt == '0)) begin
                            gt <= ~a_q[WIDTH-1];
                            lt <= a_q[WIDTH-1];
                        end else begin
                            gt <= a_q[WIDTH-1];
                            lt <= ~a_q[WIDTH-1];
                        end
                    end else if (cnt_n == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        eq     <= 1'b1;
                        gt     <= 1'b0;
                        lt     <= 1'b0;
                        cycles <= cnt_n;
                    end else begin
                        a_q <= a_q << 1;
                        b_q <= b_q << 1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed and randomized checks of seq_comparator (WIDTH=8) against an arithmetic reference model.
module tb_seq_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       signed_mode = 1'b0;
    logic       busy, done, eq, gt, lt;
    logic [3:0] cycles;

    int checks = 0;
    int failures = 0;

    seq_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy), .done(done),
        .eq(eq), .gt(gt), .lt(lt), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic compare plus position of the highest differing bit.
    task automatic model(input logic [7:0] va, input logic [7:0] vb, input logic vsm,
                         output int e, output int g, output int l, output int cyc);
        logic [7:0] x;
        x = va ^ vb;
        e = (va == vb) ? 1 : 0;
        if (vsm) g = ($signed(va) > $signed(vb)) ? 1 : 0;
        else     g = (va > vb) ? 1 : 0;
        l = (!e && !g) ? 1 : 0;
        cyc = 8;
        for (int i = 0; i < 8; i++)
            if (x[i]) cyc = 8 - i;
    endtask

    task automatic run_cmp(input logic [7:0] va, input logic [7:0] vb, input logic vsm);
        int e, g, l, cyc, n;
        model(va, vb, vsm, e, g, l, cyc);
        a = va; b = vb; signed_mode = vsm; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n <= 20) begin
            chk("busy_scan", int'(busy), 1);
            a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
            step();
            n++;
        end
        if (n > 20) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_cycle", n, cyc + 1);
            chk("busy_done", int'(busy), 1);
            chk("eq", int'(eq), e);
            chk("gt", int'(gt), g);
            chk("lt", int'(lt), l);
            chk("cycles", int'(cycles), cyc);
        end
        step();
        chk("done_clear", int'(done), 0);
        chk("busy_clear", int'(busy), 0);
    endtask

    initial begin
        int dpos[3];
        int nd, k, any_done;
        logic [7:0] ra, rb;

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_res", int'({eq, gt, lt}), 0);
        chk("rst_cycles", int'(cycles), 0);
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        run_cmp(8'h00, 8'h00, 1'b0);
        run_cmp(8'hC3, 8'h43, 1'b0);
        run_cmp(8'hC3, 8'h43, 1'b1);
        run_cmp(8'h7F, 8'h80, 1'b1);
        run_cmp(8'h12, 8'h13, 1'b0);

        // Continuous start: one compare per k'+2 cycles, never restarted mid-scan
        a = 8'h05; b = 8'h04; signed_mode = 1'b0; start = 1'b1;
        nd = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 30) start = 1'b0;
            if (done) begin
                if (nd < 3) dpos[nd] = c;
                nd++;
                chk("cont_gt", int'(gt), 1);
                chk("cont_cycles", int'(cycles), 8);
            end
        end
        chk("cont_count", nd, 3);
        chk("cont_first", dpos[0], 9);
        chk("cont_spacing", dpos[2] - dpos[1], 10);
        step();
        chk("cont_idle", int'(busy), 0);

        // start pulse confined to the done cycle is ignored
        a = 8'hC3; b = 8'h43; signed_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin step(); k++; end
        chk("pulse_done_seen", int'(done), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pulse_ignored0", int'(busy), 0);
        step();
        chk("pulse_ignored1", int'(busy), 0);

        // Reset mid-scan: no done pulse, outputs cleared
        a = 8'h01; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_res", int'({eq, gt, lt}), 0);
        chk("mid_rst_cycles", int'(cycles), 0);
        step();
        step();
        rst = 1'b0;
        any_done = 0;
        repeat (12) begin
            step();
            if (done || busy) any_done = 1;
        end
        chk("mid_rst_no_done", any_done, 0);
        run_cmp(8'h80, 8'h80, 1'b1);

        // Randomized compares, biased towards single-bit differences and equality
        for (int t = 0; t < 40; t++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            run_cmp(ra, rb, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
